dram_cmd_scheduler: RTL and testbench
=====================================

// Module: dram_cmd_scheduler
// PURPOSE
//  Issue side of the bank FSM ba_issue/stall protocol. Collects per-bank issue requests
//  (ba_issue, ba_state, ba_addr), arbitrates round-robin, enforces DRAM timing and drives one
//  command per cycle onto the DRAM command bus. Back-pressures losing or timing-blocked banks
//  via stall; sits between the bank FSM array and the PHY command interface.
// PARAMETERS
//  NUM_BANKS  4   number of bank FSMs served (power of 2, >=2)
//  ADDR_BITS  16  row/column address width (matches `ADDR_BITS)
//  T_RCD      4   min cycles ACT->RD/WR, same bank
//  T_RP       4   min cycles PRE->ACT/REF, same bank
//  T_CCD      2   min cycles between any two RD/WR, all banks
//  T_RRD      2   min cycles between any two ACT, all banks
// PORTS
//  clk          in   1                    clock, all logic on rising edge
//  rst          in   1                    synchronous, active-high reset
//  ba_issue     in   NUM_BANKS            bank i requests a command this cycle
//  ba_state     in   NUM_BANKS x bank_state_t  bank i current state (selects command)
//  ba_addr      in   NUM_BANKS x ADDR_BITS     bank i row/col address
//  stall        out  NUM_BANKS            hold bank i state this cycle
//  dram_cmd_vld out  1                    registered command valid
//  dram_cmd     out  dram_cmd_t           ACT/RD/WR/PRE/REF/NOP
//  dram_ba      out  $clog2(NUM_BANKS)    target bank
//  dram_addr    out  ADDR_BITS            row (ACT) or col (RD/WR); 0 for PRE/REF
// BEHAVIOUR
//  - Decode: B_ACTIVE->ACT, B_READ->RD, B_WRITE->WR, B_PRE->PRE, B_ISSUE_REFRESH->REF;
//    ba_issue with any other state is a protocol error: never granted, stall held 1.
//  - Eligible(i) = ba_issue[i] && timing counters for decoded cmd are zero.
//  - One grant per cycle among eligible banks, round-robin; pointer moves to grant+1 only on grant.
//  - stall[i] = ba_issue[i] && !grant[i]; banks not requesting get stall=0 (free-running FSMs).
//  - Grant cycle: cmd/ba/addr registered, dram_cmd_vld=1 next cycle (latency 1). No grant -> NOP, vld=0.
//  - Per-bank counters: rcd_cnt loaded T_RCD-1 on ACT; rp_cnt loaded T_RP-1 on PRE; decrement
//    to 0, saturate. Global ccd_cnt (T_CCD-1 on RD/WR), rrd_cnt (T_RRD-1 on ACT). Counter
//    loaded the same cycle it would decrement: load wins.
//  - REF blocked while rp_cnt of that bank != 0; REF loads rp_cnt with T_RP-1 (bank reused only after).
//  - Pointer wrap NUM_BANKS-1 -> 0. All-request, all-eligible: exactly one grant, others stall.
//  - Reset: stall=0, dram_cmd_vld=0, dram_cmd=NOP, dram_ba=0, dram_addr=0, all counters 0,
//    RR pointer 0. Reset mid-command: outputs return to reset values next edge, pending
//    requests dropped (bank FSMs also reset).
// CONFIGURATION
//  SCHED_REF_PRIORITY_EN defined: any eligible REF request beats RR order (lowest index REF wins);
//    RR pointer unchanged by a REF grant.
//  Undefined: REF arbitrated like every other command.
// STRUCTURE
//  - usertype package: dram_cmd_t enum {NOP,ACT,RD,WR,PRE,REF}; bank_state_t already there.
//  - define.sv: default timing constants T_RCD/T_RP/T_CCD/T_RRD.
//  - Sub-module rr_arbiter (NUM_BANKS req -> one-hot grant, pointer state); decode, timing
//    counters and output registers stay in top.
// TESTING
//  1 Bank0 ACT at t0, RD request at t1 -> RD stalled until t0+T_RCD (t4), dram_cmd=RD at t5, ba=0.
//  2 Banks0-3 all ACT same cycle, T_RRD=2 -> ACTs on bus at t1,t3,t5,t7 in order 0,1,2,3.
//  3 Bank1 RD and bank2 WR both eligible, T_CCD=2 -> issue 2 cycles apart, loser stall=1 between.
//  4 Bank3 PRE then REF request next cycle -> REF issued no earlier than PRE+T_RP; addr=0.
//  5 With SCHED_REF_PRIORITY_EN, ptr=0, bank0 RD + bank2 REF -> REF granted first; without, RD first.
//  6 rst=1 while dram_cmd_vld=1 -> next edge vld=0, cmd=NOP, stall=0, counters cleared.

Source files
------------

// File: rtl/dram_cmd_scheduler_pkg.sv
// Shared types, default DRAM timing and the bank-state to command decode
// used by the DRAM command scheduler.
package dram_cmd_scheduler_pkg;

    typedef enum logic [2:0] {
        B_IDLE,
        B_ACTIVE,
        B_OPEN,
        B_READ,
        B_WRITE,
        B_PRE,
        B_ISSUE_REFRESH,
        B_REFRESH
    } bank_state_t;

    typedef enum logic [2:0] {
        NOP,
        ACT,
        RD,
        WR,
        PRE,
        REF
    } dram_cmd_t;

    localparam int T_RCD_DEF = 4;
    localparam int T_RP_DEF  = 4;
    localparam int T_CCD_DEF = 2;
    localparam int T_RRD_DEF = 2;

    // Wide enough for any realistic timing parameter.
    localparam int CNT_W = 8;

    // States that do not map to a command decode to NOP and are never granted.
    function automatic dram_cmd_t decode_cmd(input bank_state_t st);
        dram_cmd_t c;
        c = NOP;
        case (st)
            B_ACTIVE:        c = ACT;
            B_READ:          c = RD;
            B_WRITE:         c = WR;
            B_PRE:           c = PRE;
            B_ISSUE_REFRESH: c = REF;
            default:         c = NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dram_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer;
// the pointer moves to grant+1 only when something is granted.
module dram_cmd_scheduler_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] scan;

    // N is a power of two, so index arithmetic wraps for free.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            scan = ptr + IDX_W'(k);
            if (!grant_vld && req[scan]) begin
                grant_vld   = 1'b1;
                grant[scan] = 1'b1;
                grant_idx   = scan;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_vld) begin
            ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dram_cmd_scheduler.sv
// DRAM command scheduler: decodes per-bank issue requests, enforces tRCD/tRP/
// tCCD/tRRD with down-counters, picks one bank per cycle and registers the command.
// SCHED_REF_PRIORITY_EN: eligible REF requests (lowest index) bypass round-robin.
module dram_cmd_scheduler
    import dram_cmd_scheduler_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_BITS = 16,
    parameter int T_RCD     = T_RCD_DEF,
    parameter int T_RP      = T_RP_DEF,
    parameter int T_CCD     = T_CCD_DEF,
    parameter int T_RRD     = T_RRD_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_BANKS-1:0]         ba_issue,
    input  bank_state_t                  ba_state [NUM_BANKS],
    input  logic [ADDR_BITS-1:0]         ba_addr  [NUM_BANKS],
    output logic [NUM_BANKS-1:0]         stall,
    output logic                         dram_cmd_vld,
    output dram_cmd_t                    dram_cmd,
    output logic [$clog2(NUM_BANKS)-1:0] dram_ba,
    output logic [ADDR_BITS-1:0]         dram_addr
);

    localparam int BA_W = $clog2(NUM_BANKS);

    dram_cmd_t            cmd_dec [NUM_BANKS];
    logic [NUM_BANKS-1:0] elig;
    logic [NUM_BANKS-1:0] arb_req;
    logic [NUM_BANKS-1:0] arb_grant;
    logic [BA_W-1:0]      arb_idx;
    logic                 arb_vld;
    logic [NUM_BANKS-1:0] grant;
    logic [BA_W-1:0]      grant_idx;
    logic                 grant_vld;
    dram_cmd_t            grant_cmd;

    logic [CNT_W-1:0] rcd_cnt [NUM_BANKS];
    logic [CNT_W-1:0] rp_cnt  [NUM_BANKS];
    logic [CNT_W-1:0] ccd_cnt;
    logic [CNT_W-1:0] rrd_cnt;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            cmd_dec[i] = decode_cmd(ba_state[i]);
            case (cmd_dec[i])
                ACT:     elig[i] = (rp_cnt[i] == '0) && (rrd_cnt == '0);
                RD, WR:  elig[i] = (rcd_cnt[i] == '0) && (ccd_cnt == '0);
                PRE:     elig[i] = 1'b1;
                REF:     elig[i] = (rp_cnt[i] == '0);
                default: elig[i] = 1'b0;
            endcase
            elig[i] = elig[i] && ba_issue[i] && !rst;
        end
    end

`ifdef SCHED_REF_PRIORITY_EN
    logic [NUM_BANKS-1:0] ref_grant;
    logic [BA_W-1:0]      ref_idx;
    logic                 ref_hit;

    // Downward scan so the lowest-index eligible REF is the one left standing.
    always_comb begin
        ref_grant = '0;
        ref_idx   = '0;
        ref_hit   = 1'b0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (elig[i] && cmd_dec[i] == REF) begin
                ref_hit = 1'b1;
                ref_idx = BA_W'(i);
            end
        end
        if (ref_hit) begin
            ref_grant[ref_idx] = 1'b1;
        end
    end

    // Masking the arbiter request keeps its pointer still on a REF win.
    assign arb_req   = ref_hit ? '0 : elig;
    assign grant     = ref_hit ? ref_grant : arb_grant;
    assign grant_idx = ref_hit ? ref_idx : arb_idx;
    assign grant_vld = ref_hit | arb_vld;
`else
    assign arb_req   = elig;
    assign grant     = arb_grant;
    assign grant_idx = arb_idx;
    assign grant_vld = arb_vld;
`endif

    dram_cmd_scheduler_rr_arbiter #(
        .N (NUM_BANKS)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    assign grant_cmd = cmd_dec[grant_idx];
    assign stall     = rst ? '0 : (ba_issue & ~grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            dram_cmd_vld <= 1'b0;
            dram_cmd     <= NOP;
            dram_ba      <= '0;
            dram_addr    <= '0;
            ccd_cnt      <= '0;
            rrd_cnt      <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                rcd_cnt[i] <= '0;
                rp_cnt[i]  <= '0;
            end
        end else begin
            dram_cmd_vld <= grant_vld;
            dram_cmd     <= grant_vld ? grant_cmd : NOP;
            dram_ba      <= grant_vld ? grant_idx : '0;
            dram_addr    <= (grant_vld && (grant_cmd inside {ACT, RD, WR}))
                            ? ba_addr[grant_idx] : '0;

            // A load always overrides the decrement of the same cycle.
            if (grant_vld && (grant_cmd == RD || grant_cmd == WR)) begin
                ccd_cnt <= CNT_W'(T_CCD - 1);
            end else if (ccd_cnt != '0) begin
                ccd_cnt <= ccd_cnt - 1'b1;
            end

            if (grant_vld && grant_cmd == ACT) begin
                rrd_cnt <= CNT_W'(T_RRD - 1);
            end else if (rrd_cnt != '0) begin
                rrd_cnt <= rrd_cnt - 1'b1;
            end

            for (int i = 0; i < NUM_BANKS; i++) begin
                if (grant[i] && grant_cmd == ACT) begin
                    rcd_cnt[i] <= CNT_W'(T_RCD - 1);
                end else if (rcd_cnt[i] != '0) begin
                    rcd_cnt[i] <= rcd_cnt[i] - 1'b1;
                end

                if (grant[i] && (grant_cmd == PRE || grant_cmd == REF)) begin
                    rp_cnt[i] <= CNT_W'(T_RP - 1);
                end else if (rp_cnt[i] != '0) begin
                    rp_cnt[i] <= rp_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: timestamp-based reference model, directed
// timing scenarios and random traffic. Honours SCHED_REF_PRIORITY_EN.
module tb_dram_cmd_scheduler;
    import dram_cmd_scheduler_pkg::*;

    localparam int NB     = 4;
    localparam int AW     = 16;
    localparam int P_RCD  = 4;
    localparam int P_RP   = 4;
    localparam int P_CCD  = 2;
    localparam int P_RRD  = 2;
    localparam int LONG_AGO = -1000;

    logic            clk = 1'b0;
    logic            rst;
    logic [NB-1:0]   ba_issue;
    bank_state_t     ba_state [NB];
    logic [AW-1:0]   ba_addr  [NB];
    logic [NB-1:0]   stall;
    logic            dram_cmd_vld;
    dram_cmd_t       dram_cmd;
    logic [1:0]      dram_ba;
    logic [AW-1:0]   dram_addr;

    dram_cmd_scheduler #(
        .NUM_BANKS (NB), .ADDR_BITS (AW),
        .T_RCD (P_RCD), .T_RP (P_RP), .T_CCD (P_CCD), .T_RRD (P_RRD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ba_issue     (ba_issue),
        .ba_state     (ba_state),
        .ba_addr      (ba_addr),
        .stall        (stall),
        .dram_cmd_vld (dram_cmd_vld),
        .dram_cmd     (dram_cmd),
        .dram_ba      (dram_ba),
        .dram_addr    (dram_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: cycle stamps of the last relevant commands.
    int now = 0;
    int m_ptr;
    int m_act [NB];
    int m_pre [NB];
    int m_act_any;
    int m_rdwr;

    int        bus_at;
    dram_cmd_t bus_cmd;
    int        bus_ba;

    int        seq_ba [$];
    int        seq_at [$];

    task automatic model_reset();
        m_ptr     = 0;
        m_act_any = LONG_AGO;
        m_rdwr    = LONG_AGO;
        for (int i = 0; i < NB; i++) begin
            m_act[i] = LONG_AGO;
            m_pre[i] = LONG_AGO;
        end
    endtask

    function automatic dram_cmd_t cmd_of(input bank_state_t st);
        if (st == B_ACTIVE)        return ACT;
        if (st == B_READ)          return RD;
        if (st == B_WRITE)         return WR;
        if (st == B_PRE)           return PRE;
        if (st == B_ISSUE_REFRESH) return REF;
        return NOP;
    endfunction

    function automatic bit can_issue(input int b, input dram_cmd_t c);
        case (c)
            ACT:     return (now - m_pre[b] >= P_RP) && (now - m_act_any >= P_RRD);
            RD, WR:  return (now - m_act[b] >= P_RCD) && (now - m_rdwr >= P_CCD);
            PRE:     return 1'b1;
            REF:     return (now - m_pre[b] >= P_RP);
            default: return 1'b0;
        endcase
    endfunction

    // One clock: entered and left at the falling edge with inputs already applied.
    task automatic step();
        int            g;
        bit            ref_won;
        logic [NB-1:0] exp_stall;
        dram_cmd_t     c;
        logic [AW-1:0] exp_addr;
        g       = -1;
        ref_won = 1'b0;
        c       = NOP;
`ifdef SCHED_REF_PRIORITY_EN
        for (int i = 0; i < NB; i++) begin
            if (g < 0 && ba_issue[i] && cmd_of(ba_state[i]) == REF && can_issue(i, REF)) begin
                g = i;
                ref_won = 1'b1;
            end
        end
`endif
        for (int k = 0; k < NB; k++) begin
            int b;
            b = (m_ptr + k) % NB;
            if (g < 0 && ba_issue[b] && can_issue(b, cmd_of(ba_state[b]))) g = b;
        end
        exp_stall = ba_issue;
        exp_addr  = '0;
        if (g >= 0) begin
            exp_stall[g] = 1'b0;
            c = cmd_of(ba_state[g]);
            if (c == ACT || c == RD || c == WR) exp_addr = ba_addr[g];
        end
        #1;
        chk("stall", stall, exp_stall);
        @(posedge clk);
        #1;
        chk("cmd_vld", dram_cmd_vld, (g >= 0));
        chk("cmd", dram_cmd, c);
        if (g >= 0) begin
            chk("ba", dram_ba, g);
            chk("addr", dram_addr, exp_addr);
        end
        bus_at  = dram_cmd_vld ? now : -1;
        bus_cmd = dram_cmd;
        bus_ba  = int'(dram_ba);
        if (g >= 0) begin
            case (c)
                ACT:     begin m_act[g] = now; m_act_any = now; end
                RD, WR:  m_rdwr = now;
                default: m_pre[g] = now;
            endcase
            if (!ref_won) m_ptr = (g + 1) % NB;
        end
        now++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        ba_issue = '0;
        @(posedge clk);
        #1;
        chk("rst_vld", dram_cmd_vld, 0);
        chk("rst_cmd", dram_cmd, NOP);
        chk("rst_ba", dram_ba, 0);
        chk("rst_addr", dram_addr, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic req(input int b, input bank_state_t st);
        ba_issue[b] = 1'b1;
        ba_state[b] = st;
        ba_addr[b]  = AW'($urandom);
    endtask

    task automatic idle(input int n);
        ba_issue = '0;
        repeat (n) step();
    endtask

    // Run until every request has been issued, clearing a bank once it appears on the bus.
    task automatic drain(input int max_cycles);
        seq_ba.delete();
        seq_at.delete();
        for (int k = 0; k < max_cycles && ba_issue != '0; k++) begin
            step();
            if (bus_at >= 0) begin
                seq_ba.push_back(bus_ba);
                seq_at.push_back(bus_at);
                ba_issue[bus_ba] = 1'b0;
            end
        end
        chk("drain_done", ba_issue, 0);
    endtask

    initial begin
        int t_act, t_rd, t_pre, t_ref;
        rst      = 1'b1;
        ba_issue = '0;
        for (int i = 0; i < NB; i++) begin
            ba_state[i] = B_IDLE;
            ba_addr[i]  = '0;
        end
        model_reset();

        // 1: ACT then RD on bank 0 spaced by tRCD.
        do_reset();
        req(0, B_ACTIVE);
        step();
        t_act = (bus_at >= 0 && bus_cmd == ACT) ? bus_at : LONG_AGO;
        ba_state[0] = B_READ;
        t_rd = LONG_AGO;
        for (int k = 0; k < 12 && t_rd == LONG_AGO; k++) begin
            step();
            if (bus_at >= 0 && bus_cmd == RD) t_rd = bus_at;
        end
        chk("t1_rcd_gap", t_rd - t_act, P_RCD);
        ba_issue = '0;

        // 2: four simultaneous ACTs issue in bank order, tRRD apart.
        do_reset();
        for (int i = 0; i < NB; i++) req(i, B_ACTIVE);
        drain(30);
        chk("t2_count", seq_ba.size(), NB);
        for (int i = 0; i < seq_ba.size(); i++) begin
            chk("t2_order", seq_ba[i], i);
            if (i > 0) chk("t2_rrd_gap", seq_at[i] - seq_at[i-1], P_RRD);
        end

        // 3: RD on bank 1 and WR on bank 2 separated by tCCD.
        do_reset();
        req(1, B_ACTIVE);
        req(2, B_ACTIVE);
        drain(20);
        idle(4);
        req(1, B_READ);
        req(2, B_WRITE);
        drain(20);
        chk("t3_count", seq_ba.size(), 2);
        if (seq_ba.size() == 2) begin
            chk("t3_first", seq_ba[0], 1);
            chk("t3_ccd_gap", seq_at[1] - seq_at[0], P_CCD);
        end

        // 4: REF right after PRE waits out tRP.
        do_reset();
        req(3, B_PRE);
        drain(10);
        t_pre = (seq_at.size() > 0) ? seq_at[0] : LONG_AGO;
        req(3, B_ISSUE_REFRESH);
        drain(20);
        t_ref = (seq_at.size() > 0) ? seq_at[0] : 0;
        chk("t4_rp_gap", t_ref - t_pre, P_RP);

        // 5: RD on bank 0 against REF on bank 2 with the pointer at 0.
        do_reset();
        req(0, B_READ);
        req(2, B_ISSUE_REFRESH);
        drain(20);
        chk("t5_count", seq_ba.size(), 2);
`ifdef SCHED_REF_PRIORITY_EN
        chk("t5_first", (seq_ba.size() > 0) ? seq_ba[0] : -1, 2);
`else
        chk("t5_first", (seq_ba.size() > 0) ? seq_ba[0] : -1, 0);
`endif

        // 6: reset while a command is on the bus.
        do_reset();
        req(0, B_ACTIVE);
        step();
        chk("t6_vld_before", dram_cmd_vld, 1);
        rst = 1'b1;
        ba_state[0] = B_READ;
        @(posedge clk);
        #1;
        chk("t6_vld", dram_cmd_vld, 0);
        chk("t6_cmd", dram_cmd, NOP);
        chk("t6_ba", dram_ba, 0);
        chk("t6_addr", dram_addr, 0);
        chk("t6_stall", stall, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step();
        chk("t6_rd_after_rst", (bus_at >= 0 && bus_cmd == RD), 1);
        ba_issue = '0;

        // Random traffic, including illegal states and pointer wrap.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < NB; i++) begin
                ba_issue[i] = ($urandom_range(0, 2) != 0);
                ba_state[i] = bank_state_t'($urandom_range(0, 7));
                ba_addr[i]  = AW'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
